// File: rtl/panda_writeback_if.sv
// Bundle for the panda_writeback producer channels (ALU, LSU load) and the register-file rd write port.
// The slave modport is the writeback stage; the master modport is the producer/register-file side.
interface panda_writeback_if;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_addr_i;
  logic [31:0] alu_rd_data_i;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rdata_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_byte_off_i;

  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_we_o;

  modport slave (
    input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
    output alu_ready_o, lsu_ready_o,
    output rd_addr_o, rd_data_o, rd_we_o
  );

  modport master (
    output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
    input  alu_ready_o, lsu_ready_o,
    input  rd_addr_o, rd_data_o, rd_we_o
  );
endinterface

// File: rtl/panda_writeback.sv
// Panda writeback stage: arbitrates ALU and load results onto the register-file rd port with one cycle latency.
// Optional retired-transfer counter instret_o is enabled with `define PANDA_WB_INSTRET_EN.
module panda_writeback #(
  parameter int LOAD_STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  panda_writeback_if.slave  wb
`ifdef PANDA_WB_INSTRET_EN
  ,
  output logic [63:0]       instret_o
`endif
);

  localparam int DATA_W = 32;

  // Load data formatting by funct3 and byte offset; unknown funct3 yields zero.
  function automatic logic signed [DATA_W-1:0] load_format(
    input logic [DATA_W-1:0] word,
    input logic [2:0]        funct3,
    input logic [1:0]        off
  );
    logic [DATA_W-1:0]       shifted;
    logic signed [7:0]       b;
    logic signed [15:0]      h;
    logic signed [DATA_W-1:0] r;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = DATA_W'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = DATA_W'(h);
      3'b101:  r = {16'h0, h};
      3'b010:  r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [3:0]               starve_cnt;
  logic                     force_lsu;
  logic                     alu_xfer;
  logic                     lsu_xfer;
  logic                     any_xfer;
  logic [4:0]               sel_addr_p0;
  logic signed [DATA_W-1:0] sel_data_p0;
  logic signed [DATA_W-1:0] load_data_p0;

  logic                     vld_p1;
  logic [4:0]               rd_addr_p1;
  logic signed [DATA_W-1:0] rd_data_p1;

  assign force_lsu      = wb.lsu_valid_i && (starve_cnt == 4'(LOAD_STARVE_MAX));
  assign wb.alu_ready_o = !rst_i && !force_lsu;
  assign wb.lsu_ready_o = !rst_i && (!wb.alu_valid_i || force_lsu);

  // The two ready terms are mutually exclusive whenever the ALU is valid, so at most one transfer fires.
  assign alu_xfer = wb.alu_valid_i && wb.alu_ready_o;
  assign lsu_xfer = wb.lsu_valid_i && wb.lsu_ready_o && !alu_xfer;
  assign any_xfer = alu_xfer || lsu_xfer;

  assign load_data_p0 = load_format(wb.lsu_rdata_i, wb.lsu_funct3_i, wb.lsu_byte_off_i);

  always_comb begin
    sel_addr_p0 = wb.alu_rd_addr_i;
    sel_data_p0 = wb.alu_rd_data_i;
    if (lsu_xfer) begin
      sel_addr_p0 = wb.lsu_rd_addr_i;
      sel_data_p0 = load_data_p0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (alu_xfer && wb.lsu_valid_i) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else if (lsu_xfer || !wb.lsu_valid_i) begin
      starve_cnt <= '0;
    end
  end

  // ---- p0 -> p1 : output register feeding the register file ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      rd_addr_p1 <= '0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= any_xfer && (sel_addr_p0 != 5'd0);
      if (any_xfer) begin
        rd_addr_p1 <= sel_addr_p0;
        rd_data_p1 <= sel_data_p0;
      end
    end
  end

  assign wb.rd_we_o   = vld_p1;
  assign wb.rd_addr_o = rd_addr_p1;
  assign wb.rd_data_o = rd_data_p1;

`ifdef PANDA_WB_INSTRET_EN
  logic [63:0] instret_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_p1 <= '0;
    end else if (any_xfer) begin
      instret_p1 <= instret_p1 + 64'd1;
    end
  end

  assign instret_o = instret_p1;
`endif

  starve_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    starve_cnt <= 4'(LOAD_STARVE_MAX));

endmodule
